// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage IEEE-754 single-precision rounding and packing pipeline
module fp_rnd_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sig,
  input  logic [9:0]  in_expo,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  input  logic [2:0]  in_rm,
  input  logic        in_snan,
  input  logic        in_qnan,
  input  logic        in_dbz,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);
  logic        s1_valid, s1_sig, s1_inc, s1_nx, s1_snan, s1_qnan, s1_dbz, s1_inf, s1_zero;
  logic [9:0]  s1_expo;
  logic [24:0] s1_mant;
  logic [2:0]  s1_rm;
  logic        s2_free, take, inc, ovf, to_inf;
  logic [24:0] sum;
  logic [22:0] frac;
  logic [10:0] expo;
  logic [31:0] res;
  logic [4:0]  flg;
  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign take     = in_valid & in_ready;
  assign inc = in_rm == 3'd1 ? 1'b0 :
               in_rm == 3'd2 ? in_sig & |in_grs :
               in_rm == 3'd3 ? ~in_sig & |in_grs :
               in_rm == 3'd4 ? in_grs[2] :
               in_grs[2] & (in_mant[0] | |in_grs[1:0]);
  assign sum    = s1_mant + {24'd0, s1_inc};
  assign frac   = sum[24] ? sum[23:1] : sum[22:0];
  assign expo   = {1'b0, s1_expo} + {10'd0, sum[24]};
  assign ovf    = expo >= 11'd255;
  assign to_inf = s1_rm == 3'd1 ? 1'b0 : s1_rm == 3'd2 ? s1_sig : s1_rm == 3'd3 ? ~s1_sig : 1'b1;
  assign res = (s1_snan | s1_qnan) ? 32'h7FC0_0000 :
               s1_inf  ? {s1_sig, 8'hFF, 23'd0} :
               s1_zero ? {s1_sig, 31'd0} :
               ovf     ? {s1_sig, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF} :
               {s1_sig, expo[7:0], frac};
  assign flg = s1_snan ? 5'b10000 :
               s1_qnan ? 5'b00000 :
               s1_inf  ? {1'b0, s1_dbz, 3'b000} :
               s1_zero ? 5'b00000 :
               ovf     ? 5'b00101 :
               {4'd0, s1_nx};
  // stage 1 captures the record with its increment decision and holds it until stage 2 frees up
  always_ff @(posedge clock) begin
    s1_valid <= reset ? 1'b0 : take | (s1_valid & ~s2_free);
    if (take) begin
      s1_sig  <= in_sig;
      s1_expo <= in_expo;
      s1_mant <= in_mant;
      s1_rm   <= in_rm;
      s1_inc  <= inc;
      s1_nx   <= |in_grs;
      s1_snan <= in_snan;
      s1_qnan <= in_qnan;
      s1_dbz  <= in_dbz;
      s1_inf  <= in_inf;
      s1_zero <= in_zero;
    end
  end
  // stage 2 registers the packed result and flags, holding them while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_flags  <= 5'd0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_flags  <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// tb_fp_rnd_pipe: directed and randomized checks of fp_rnd_pipe against a value-level rounding model
module tb_fp_rnd_pipe;
  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic        snan, qnan, dbz, inf, zero;
  } rec_t;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic        in_sig = 1'b0, in_snan = 1'b0, in_qnan = 1'b0, in_dbz = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
  logic [9:0]  in_expo = '0;
  logic [24:0] in_mant = '0;
  logic [2:0]  in_grs = '0, in_rm = '0;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  int          total = 0, bad = 0;
  logic [36:0] exp_q[$];
  rec_t        cur = '0;

  fp_rnd_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_expo(in_expo), .in_mant(in_mant), .in_grs(in_grs), .in_rm(in_rm),
    .in_snan(in_snan), .in_qnan(in_qnan), .in_dbz(in_dbz), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic rec_t mk(logic s, logic [9:0] e, logic [24:0] m, logic [2:0] g, logic [2:0] rm);
    rec_t r = '0;
    r.sig = s; r.expo = e; r.mant = m; r.grs = g; r.rm = rm;
    return r;
  endfunction

  function automatic rec_t rnd_rec();
    rec_t r = mk(1'($urandom), 10'($urandom_range(1, 254)), {2'b01, 23'($urandom)}, 3'($urandom), 3'($urandom));
    int sel = $urandom_range(0, 19);
    if (sel == 0) r.snan = 1'b1;
    if (sel == 1) r.qnan = 1'b1;
    if (sel == 2) begin r.inf = 1'b1; r.dbz = 1'($urandom); end
    if (sel == 3) r.zero = 1'b1;
    if (sel == 4) begin r.expo = 10'd254; r.mant = 25'hFFFFFF; end
    return r;
  endfunction

  function automatic void drive(rec_t r);
    cur = r;
    in_sig = r.sig; in_expo = r.expo; in_mant = r.mant; in_grs = r.grs; in_rm = r.rm;
    in_snan = r.snan; in_qnan = r.qnan; in_dbz = r.dbz; in_inf = r.inf; in_zero = r.zero;
  endfunction

  // rounds by comparing the discarded fraction against half an ulp
  function automatic logic [36:0] model(rec_t r);
    int unsigned m = r.mant;
    int          e = r.expo;
    bit          up, nx, to_inf;
    if (r.snan) return {32'h7FC00000, 5'b10000};
    if (r.qnan) return {32'h7FC00000, 5'b00000};
    if (r.inf)  return {r.sig, 31'h7F800000, 1'b0, r.dbz, 3'b000};
    if (r.zero) return {r.sig, 31'd0, 5'b00000};
    nx = r.grs != 3'b000;
    case (r.rm)
      3'd1:    up = 1'b0;
      3'd2:    up = r.sig && nx;
      3'd3:    up = !r.sig && nx;
      3'd4:    up = r.grs >= 3'b100;
      default: up = r.grs > 3'b100 || (r.grs == 3'b100 && m % 2 == 1);
    endcase
    m = m + (up ? 1 : 0);
    if (m >= 32'h1000000) begin m = m / 2; e = e + 1; end
    if (e >= 255) begin
      to_inf = !(r.rm == 3'd1 || (r.rm == 3'd2 && !r.sig) || (r.rm == 3'd3 && r.sig));
      return {r.sig, to_inf ? 31'h7F800000 : 31'h7F7FFFFF, 5'b00101};
    end
    return {r.sig, e[7:0], m[22:0], 4'b0000, nx};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // one cycle: check any presented output against the scoreboard, record accepts, advance past the edge
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (out_valid) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL extra_out observed=%h expected=none", out_result);
      end
      if (exp_q.size() > 0) begin
        chk("out", {out_result, out_flags}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(model(cur));
    @(posedge clock);
    #1;
  endtask

  task automatic send_check(string tag, rec_t r, logic [36:0] want);
    bit a;
    out_ready = 1'b1;
    drive(r);
    in_valid = 1'b1;
    tick(a);
    chk({tag, "_accept"}, a, 1);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick(a);
    chk({tag, "_lat2"}, out_valid, 1);
    chk(tag, {out_result, out_flags}, want);
    tick(a);
  endtask

  initial begin
    bit   a;
    int   n, k;
    rec_t q4[4];
    rec_t r;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_state", {out_valid, in_ready, out_result, out_flags}, {1'b0, 1'b1, 32'd0, 5'd0});

    send_check("basic", mk(0, 127, 25'h800000, 3'b000, 0), {32'h3F800000, 5'b00000});
    send_check("tie_rne", mk(0, 151, 25'h800000, 3'b100, 0), {32'h4B800000, 5'b00001});
    send_check("tie_rup", mk(0, 151, 25'h800000, 3'b100, 3), {32'h4B800001, 5'b00001});
    send_check("carry", mk(0, 127, 25'hFFFFFF, 3'b100, 0), {32'h40000000, 5'b00001});
    send_check("ovf_rne", mk(0, 254, 25'hFFFFFF, 3'b111, 0), {32'h7F800000, 5'b00101});
    send_check("ovf_rtz", mk(0, 254, 25'hFFFFFF, 3'b111, 1), {32'h7F7FFFFF, 5'b00001});
    send_check("ovf_rdn", mk(1, 254, 25'hFFFFFF, 3'b111, 2), {32'hFF800000, 5'b00101});
    r = mk(0, 127, 25'h800000, 3'b000, 0); r.snan = 1'b1;
    send_check("snan", r, {32'h7FC00000, 5'b10000});
    r = mk(1, 127, 25'h800000, 3'b000, 0); r.inf = 1'b1; r.dbz = 1'b1;
    send_check("inf_dbz", r, {32'hFF800000, 5'b01000});

    for (int i = 0; i < 4; i++) q4[i] = rnd_rec();
    out_ready = 1'b0;
    drive(q4[0]); in_valid = 1'b1;
    tick(a); chk("bp_acc0", a, 1);
    drive(q4[1]);
    tick(a); chk("bp_acc1", a, 1);
    drive(q4[2]);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    tick(a); chk("bp_no_acc", a, 0);
    out_ready = 1'b1;
    n = 2;
    k = 0;
    while (n < 4 && k < 20) begin
      drive(q4[n]); in_valid = 1'b1;
      tick(a);
      if (a) n++;
      k++;
    end
    chk("bp_sent", n, 4);
    in_valid = 1'b0;
    repeat (4) tick(a);
    chk("bp_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    drive(rnd_rec()); in_valid = 1'b1;
    tick(a);
    drive(rnd_rec());
    tick(a);
    chk("mid_full", {out_valid, in_ready}, 2'b10);
    reset = 1'b1;
    drive(rnd_rec());
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("mid_rst_state", {out_valid, in_ready, out_result, out_flags}, {1'b0, 1'b1, 32'd0, 5'd0});
    send_check("post_rst", mk(1, 130, 25'hC00000, 3'b011, 1), {32'hC1400000, 5'b00001});

    for (int c = 0; c < 400; c++) begin
      drive(rnd_rec());
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      tick(a);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick(a);
    chk("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_rnd_pipe.md
FP_RND_PIPE -- requirements
Module: fp_rnd_pipe

Interface
REQ-001 SHALL have ports: clock  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  rounding record present.
REQ-004 SHALL have ports: in_ready  out  1  record accepted when in_valid & in_ready.
REQ-005 SHALL have ports: in_sig  in  1  sign of the result.
REQ-006 SHALL have ports: in_expo  in  10  unsigned biased exponent, bias 127.
REQ-007 SHALL have ports: in_mant  in  25  significand; bit 23 is the hidden one, bit 24 is zero on input.
REQ-008 SHALL have ports: in_grs  in  3  {guard, round, sticky}.
REQ-009 SHALL have ports: in_rm  in  3  rounding mode: 0 rne, 1 rtz, 2 rdn, 3 rup, 4 rmm; 5-7 handled as rne.
REQ-010 SHALL have ports: in_snan, in_qnan, in_dbz, in_inf, in_zero  in  1 each  special-case flags from the producing converter.
REQ-011 SHALL have ports: out_valid  out  1  result present.
REQ-012 SHALL have ports: out_ready  in  1  consumer accepts when out_valid & out_ready.
REQ-013 SHALL have ports: out_result  out  32  IEEE-754 single-precision result.
REQ-014 SHALL have ports: out_flags  out  5  {NV, DZ, OF, UF, NX}; NV is bit 4.

Function
REQ-015 SHALL be a 2-stage pipeline; a record accepted in cycle N appears on out_valid in cycle N+2 when out_ready is held high.
REQ-016 Stage 1 SHALL register the record plus the increment decision: rne g&(lsb|r|s); rtz 0; rdn sig&(g|r|s); rup ~sig&(g|r|s); rmm g.
REQ-017 Stage 1 SHALL register inexact = g|r|s.
REQ-018 Stage 2 SHALL compute mant+inc in 25 bits; if bit 24 is set, the mantissa SHALL shift right by 1 and the exponent SHALL increment.
REQ-019 Overflow SHALL be flagged when the post-rounding exponent is >= 255, setting OF and NX.
REQ-020 On overflow the result SHALL be signed infinity for rne, rmm, rup&~sig and rdn&sig; otherwise it SHALL be signed 0x7F7FFFFF magnitude.
REQ-021 Non-overflowing results SHALL pack as {sig, expo[7:0], mant[22:0]}, with NX = inexact.
REQ-022 Priority SHALL be snan > qnan > inf > zero > normal.
REQ-023 snan SHALL produce 0x7FC00000 with flags 10000.
REQ-024 qnan SHALL produce 0x7FC00000 with flags 00000.
REQ-025 inf SHALL produce signed infinity with flags {0, dbz, 000}.
REQ-026 zero SHALL produce {sig, 31'h0} with flags 00000.
REQ-027 UF SHALL always be 0, since in_expo >= 1 is guaranteed for normal records.
REQ-028 Stall: stage 2 SHALL hold while out_valid & ~out_ready.
REQ-029 Stage 1 SHALL advance only into an empty or draining stage 2.
REQ-030 in_ready SHALL = ~s1_valid | s2_free, where s2_free = ~s2_valid | out_ready; it SHALL depend on no in_* input.
REQ-031 out_result and out_flags SHALL stay stable while out_valid & ~out_ready.
REQ-032 Simultaneous accept and drain in one cycle SHALL sustain one record per cycle with no bubble.
REQ-033 Records SHALL leave in acceptance order with none lost or duplicated.

Reset
REQ-034 While reset is high at a clock edge, s1_valid and s2_valid SHALL clear, irrespective of any handshake in that cycle.
REQ-035 The cycle after reset, outputs SHALL be out_valid 0, in_ready 1, out_result 0 and out_flags 0.
REQ-036 Reset asserted with records in flight SHALL discard them; no stale result SHALL appear after reset is released.

Verification
REQ-037 Bench SHALL cover basic conversion: sig0 expo127 mant 0x800000 grs000 rm0 -> 0x3F800000, flags 00000, out_valid exactly 2 cycles after accept.
REQ-038 Bench SHALL cover the tie case: expo151 mant 0x800000 grs100 -> rne 0x4B800000 NX (00001); rup 0x4B800001 NX.
REQ-039 Bench SHALL cover mantissa carry: expo127 mant 0xFFFFFF grs100 rne -> 0x40000000, flags 00001.
REQ-040 Bench SHALL cover overflow: expo254 mant 0xFFFFFF grs111 -> rne 0x7F800000 flags 00101; rtz 0x7F7FFFFF flags 00001; rdn with sig1 0xFF800000 flags 00101.
REQ-041 Bench SHALL cover specials and backpressure: snan -> 0x7FC00000/10000; inf+dbz sig1 -> 0xFF800000/01000; 4 back-to-back records with out_ready low 3 cycles -> in_ready low after 2 accepts, all 4 delivered in order and unchanged while stalled.
REQ-042 Bench SHALL cover reset mid-operation: reset with both stages valid -> next cycle out_valid 0, in_ready 1; the next record yields a correct result at +2 cycles.
